// File: rtl/w_input_conditioner.sv
//==============================================================================
// Module      : w_input_conditioner
// Description : Synchronises and debounces the raw w source; emits rise/fall
//               strobes, a busy flag and a saturating rejected-glitch count.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module w_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GLITCH_W        = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                w_raw,
    output logic                w,
    output logic                w_rise,
    output logic                w_fall,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_count
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt, cnt_inc;
    logic                   glitch;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], w_raw};
        end
    end

    assign s       = sync_q[SYNC_STAGES-1];
    assign cnt_inc = cnt + CNT_ONE;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        glitch    = 1'b0;
        case (state)
            STABLE_LO: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt = STABLE_HI;
                    end else begin
                        state_nxt = CHK_HI;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            CHK_HI: begin
                if (s) begin
                    if (cnt_inc == CNT_LAST) begin
                        state_nxt = STABLE_HI;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt   = cnt_inc;
                    end
                end else begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                    glitch    = 1'b1;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt = STABLE_LO;
                    end else begin
                        state_nxt = CHK_LO;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            CHK_LO: begin
                if (!s) begin
                    if (cnt_inc == CNT_LAST) begin
                        state_nxt = STABLE_LO;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt   = cnt_inc;
                    end
                end else begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                    glitch    = 1'b1;
                end
            end
            default: begin
                state_nxt = STABLE_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= STABLE_LO;
            cnt          <= '0;
            w            <= 1'b0;
            w_rise       <= 1'b0;
            w_fall       <= 1'b0;
            busy         <= 1'b0;
            glitch_count <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            w      <= (state_nxt == STABLE_HI) || (state_nxt == CHK_LO);
            busy   <= (state_nxt == CHK_HI) || (state_nxt == CHK_LO);
            // A rejected glitch returns to the stable state it left: no strobe.
            w_rise <= (state_nxt == STABLE_HI) && ((state == CHK_HI) || (state == STABLE_LO));
            w_fall <= (state_nxt == STABLE_LO) && ((state == CHK_LO) || (state == STABLE_HI));
            if (glitch && (glitch_count != '1)) begin
                glitch_count <= glitch_count + GLITCH_W'(1);
            end
        end
    end

endmodule

`default_nettype wire
